// File: rtl/conv_pkg.sv
// Shared encodings for the convolution buffer responder: host transfer modes and FSM states.
package conv_pkg;
  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_DUMP = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_LOAD = 4'b0010,
    S_DUMP = 4'b0100,
    S_DONE = 4'b1000
  } state_t;
endpackage

// File: rtl/conv_buf_responder_spram.sv
// Single-port synchronous RAM, DEPTH x DATA_WIDTH, one-cycle read latency.
module conv_spram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/conv_buf_responder.sv
// Buffer responder: engine port (priority) and host load/dump streaming port sharing one RAM.
module conv_buf_responder
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  buf_cs,
  input  logic                  buf_ren,
  input  logic                  buf_wen,
  input  logic [ADDR_WIDTH-1:0] buf_addr,
  input  logic [DATA_WIDTH-1:0] buf_din,
  output logic [DATA_WIDTH-1:0] buf_dout,
  input  logic                  host_mode,
  input  logic                  host_start,
  input  logic [ADDR_WIDTH-1:0] host_base,
  input  logic [ADDR_WIDTH-1:0] host_len,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_wvalid,
  output logic                  host_wready,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  input  logic                  host_rready,
  output logic                  host_busy,
  output logic                  host_done,
  output logic                  addr_err
);
  localparam int AW = $clog2(DEPTH);

  state_t                state, state_n;
  logic [AW-1:0]         ptr, ptr_next;
  logic [ADDR_WIDTH-1:0] to_issue, to_take;
  logic                  in_range, eng_wr, eng_rd, host_wr, pop, issue;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  logic                  eng_rd_q, oob_rd_q, rd_pend_q;
  logic [DATA_WIDTH-1:0] dout_hold, rdata_hold;

  assign in_range = 32'(buf_addr) < 32'(DEPTH);
  assign eng_wr   = buf_cs & ~buf_wen;
  assign eng_rd   = buf_cs & ~buf_ren & buf_wen;   // write wins when both strobes are low
  assign host_wr  = (state == S_LOAD) & host_wvalid & host_wready;
  assign pop      = host_rvalid & host_rready;
  assign issue    = (state == S_DUMP) & ~buf_cs & (to_issue != '0) & (~host_rvalid | pop);
  assign ptr_next = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;

  // Engine owns the RAM whenever it is selected; the host only gets idle cycles.
  assign ram_we    = buf_cs ? (eng_wr & in_range) : host_wr;
  assign ram_addr  = buf_cs ? buf_addr[AW-1:0] : ptr;
  assign ram_wdata = buf_cs ? buf_din : host_wdata;

  conv_spram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM output is shared, so each consumer forwards it only the cycle after its own read.
  assign buf_dout   = eng_rd_q ? ram_rdata : (oob_rd_q ? '0 : dout_hold);
  assign host_rdata = rd_pend_q ? ram_rdata : rdata_hold;
  assign host_busy  = (state != S_IDLE);

  always_comb begin
    state_n     = state;
    host_wready = 1'b0;
    host_done   = 1'b0;
    unique case (state)
      S_IDLE: if (host_start)
        state_n = (host_len == '0) ? S_DONE : ((host_mode == MODE_DUMP) ? S_DUMP : S_LOAD);
      S_LOAD: begin
        host_wready = ~buf_cs;
        if (host_wr && to_issue == ADDR_WIDTH'(1)) state_n = S_DONE;
      end
      S_DUMP: if (pop && to_take == ADDR_WIDTH'(1)) state_n = S_DONE;
      S_DONE: begin
        host_done = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      ptr         <= '0;
      to_issue    <= '0;
      to_take     <= '0;
      host_rvalid <= 1'b0;
      rd_pend_q   <= 1'b0;
      rdata_hold  <= '0;
      eng_rd_q    <= 1'b0;
      oob_rd_q    <= 1'b0;
      dout_hold   <= '0;
      addr_err    <= 1'b0;
    end else begin
      state      <= state_n;
      rd_pend_q  <= issue;
      rdata_hold <= host_rdata;
      eng_rd_q   <= eng_rd & in_range;
      oob_rd_q   <= eng_rd & ~in_range;
      dout_hold  <= buf_dout;
      if ((eng_rd | eng_wr) && !in_range) addr_err <= 1'b1;

      if (state == S_IDLE && host_start) begin
        ptr      <= AW'(32'(host_base) % 32'(DEPTH));
        to_issue <= host_len;
        to_take  <= host_len;
      end else begin
        if (host_wr || issue) begin
          ptr      <= ptr_next;
          to_issue <= to_issue - 1'b1;
        end
        if (pop) to_take <= to_take - 1'b1;
      end

      if (issue)    host_rvalid <= 1'b1;
      else if (pop) host_rvalid <= 1'b0;
    end
  end
endmodule
